// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: 2x2 stride-2 max-pool sequencer (hold reg, line buffer, 4-entry output FIFO); MAXPOOL_RELU_EN clamps negative bytes.
// Latency: pooled beat appears on m_valid 3 cycles after the odd-row/odd-col input beat is accepted.
// Backpressure: s_ready is registered and drops once the FIFO holds 2 entries; m_data holds while stalled.

`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif
`ifndef AXI_WIDTH_DATA_IN
`define AXI_WIDTH_DATA_IN (16*8*`PICTURE_NUM)
`endif

// sync_fifo: generic single-clock FIFO, power-of-two depth, storage cleared on reset.
// Latency: written entry visible on rd_vld the cycle after the write.
// Backpressure: writes dropped when full; head held stable until rd_rdy.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_vld,
    input  logic [W-1:0]               wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_fire, rd_fire;

    assign rd_vld  = (count != '0);
    assign rd_dat  = mem[rd_ptr];
    assign wr_fire = wr_vld && (count != FULL);
    assign rd_fire = rd_rdy && rd_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// compare_maxpool: per-byte signed max of two pixel vectors.
// Latency: 1 cycle, registered; result updates only when en is high.
// Backpressure: none, caller gates en.
module compare_maxpool #(
    parameter int LANES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [LANES*8-1:0] a,
    input  logic [LANES*8-1:0] b,
    output logic [LANES*8-1:0] max_dat
);
    logic [LANES*8-1:0] max_d;

    always_comb begin
        max_d = '0;
        for (int i = 0; i < LANES; i++)
            max_d[i*8 +: 8] = ($signed(a[i*8 +: 8]) > $signed(b[i*8 +: 8])) ? a[i*8 +: 8] : b[i*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    max_dat <= '0;
        else if (en) max_dat <= max_d;
    end
endmodule

module maxpool_ctrl #(
    parameter int RE_CHANNEL_IN_NUM = 16,
    parameter int COL_W             = 9,
    parameter int ROW_W             = 9,
    parameter int LINE_DEPTH        = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [COL_W-1:0]              col_num,
    input  logic [ROW_W-1:0]              row_num,
    input  logic                          s_valid,
    input  logic [`AXI_WIDTH_DATA_IN-1:0] s_data,
    output logic                          s_ready,
    output logic                          m_valid,
    output logic [`AXI_WIDTH_DATA_IN-1:0] m_data,
    input  logic                          m_ready,
    output logic                          busy,
    output logic                          done
);
    localparam int DW         = `AXI_WIDTH_DATA_IN;
    localparam int LANES      = RE_CHANNEL_IN_NUM * `PICTURE_NUM;
    localparam int LB_AW      = $clog2(LINE_DEPTH);
    localparam int FIFO_DEPTH = 4;
    localparam int FC_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FC_W-1:0] RDY_MAX_CNT = FC_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic             armed;
    logic [COL_W-1:0] col_q, col_num_q;
    logic [ROW_W-1:0] row_q, row_num_q;
    logic             zero_q, zero_d;
    logic             s_ready_q, s_ready_d;
    logic             s_fire, col_last, last_beat, start_ok;
    logic             h_en, lb_rd_en;
    logic [LB_AW-1:0] lb_addr, s1_addr;
    logic             s1_vld, s1_wr, s2_vld;
    logic [DW-1:0]    hold_q, hmax, vmax, lb_rd_dat, fifo_wr_dat;
    logic [DW-1:0]    line_buf [LINE_DEPTH];
    logic [FC_W-1:0]  fifo_count;

    assign s_ready   = s_ready_q;
    assign s_fire    = s_valid && s_ready_q;
    assign start_ok  = start && armed;
    assign col_last  = (col_q == col_num_q - COL_W'(1));
    assign last_beat = col_last && (row_q == row_num_q - ROW_W'(1));
    assign h_en      = s_fire && col_q[0];
    assign lb_rd_en  = h_en && row_q[0];
    assign lb_addr   = LB_AW'(col_q >> 1);
    assign zero_d    = (state_q == IDLE) ? ((col_num == '0) || (row_num == '0)) : zero_q;

    // Counting current FIFO occupancy only is enough: windows are at least two beats apart.
    assign s_ready_d = (state_d == RUN) && !zero_d && (fifo_count <= RDY_MAX_CNT);

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) state_d = RUN;
            end
            RUN:     if (zero_q || (s_fire && last_beat)) state_d = FLUSH;
            FLUSH:   if (!s1_vld && !s2_vld && !m_valid) state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            armed     <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed     <= 1'b1;
            s_ready_q <= s_ready_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            col_num_q <= '0;
            row_num_q <= '0;
            zero_q    <= 1'b0;
        end else if (state_q == IDLE && start_ok) begin
            col_q     <= '0;
            row_q     <= '0;
            col_num_q <= col_num;
            row_num_q <= row_num;
            zero_q    <= zero_d;
        end else if (s_fire) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Trailing odd column/row beats land in hold or line buffer but never reach the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q  <= '0;
            s1_vld  <= 1'b0;
            s1_wr   <= 1'b0;
            s1_addr <= '0;
            s2_vld  <= 1'b0;
        end else begin
            if (s_fire && !col_q[0]) hold_q <= s_data;
            s1_vld  <= lb_rd_en;
            s1_wr   <= h_en && !row_q[0];
            s1_addr <= lb_addr;
            s2_vld  <= s1_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_wr)    line_buf[s1_addr] <= hmax;
        if (lb_rd_en) lb_rd_dat         <= line_buf[lb_addr];
    end

    compare_maxpool #(.LANES(LANES)) u_cmp_h (
        .clk     (clk),
        .rst     (rst),
        .en      (h_en),
        .a       (hold_q),
        .b       (s_data),
        .max_dat (hmax)
    );

    compare_maxpool #(.LANES(LANES)) u_cmp_v (
        .clk     (clk),
        .rst     (rst),
        .en      (s1_vld),
        .a       (lb_rd_dat),
        .b       (hmax),
        .max_dat (vmax)
    );

    always_comb begin
        fifo_wr_dat = vmax;
`ifdef MAXPOOL_RELU_EN
        for (int i = 0; i < LANES; i++)
            if (vmax[i*8+7]) fifo_wr_dat[i*8 +: 8] = 8'h00;
`endif
    end

    sync_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (s2_vld),
        .wr_dat (fifo_wr_dat),
        .rd_rdy (m_ready),
        .rd_vld (m_valid),
        .rd_dat (m_data),
        .count  (fifo_count)
    );
endmodule

// File: tb/tb_maxpool_ctrl.sv
// Bench for maxpool_ctrl: table of map sizes with hand-computed pooled bytes,
// plus backpressure, mid-map reset and start-while-busy sequences.
module tb_maxpool_ctrl;
    localparam int DW    = 128;
    localparam int LANES = 16;

    typedef struct {
        int          cn;
        int          rn;
        int          mode;
        int          n;
        logic [31:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [8:0]    col_num, row_num;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DW-1:0] outq[$];
    int mv_seen, first_mv_cyc, done_cnt, done_cyc, last_hs_cyc, acc11_cyc, acc_cnt;

    maxpool_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .col_num (col_num),
        .row_num (row_num),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        #1;
        if (m_valid && m_ready) begin
            outq.push_back(m_data);
            last_hs_cyc = cyc;
        end
        if (m_valid && mv_seen == 0) begin
            mv_seen      = 1;
            first_mv_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {LANES{b}};
    endfunction

    function automatic logic [7:0] pix_val(input int mode, input int r, input int c, input int cn);
        logic [31:0] sv;
        sv = 32'hF0FE_8180;
        if (mode == 1) return sv[(r*2+c)*8 +: 8];
        return 8'(r*cn + c);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_map(input int cn, input int rn);
        outq.delete();
        mv_seen  = 0;
        done_cnt = 0;
        col_num  = 9'(cn);
        row_num  = 9'(rn);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic drive(input int cn, input int rn, input int mode, input int nbeats);
        int   idx   = 0;
        int   guard = 0;
        int   r, c;
        logic fire;
        acc_cnt = 0;
        while (idx < nbeats && guard < 2000) begin
            r       = idx / cn;
            c       = idx % cn;
            s_valid = 1'b1;
            s_data  = rep(pix_val(mode, r, c, cn));
            fire    = s_ready;
            if (fire && r == 1 && c == 1) acc11_cyc = cyc;
            @(negedge clk);
            if (fire) begin
                idx++;
                acc_cnt = idx;
            end
            guard++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        check($sformatf("beats_accepted_%0dx%0d", cn, rn), idx, nbeats);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!(done_cnt > 0 && !busy) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int n, input logic [31:0] exp);
        check({tag, "_count"}, outq.size(), n);
        for (int k = 0; k < n && k < outq.size(); k++)
            check($sformatf("%s_beat%0d", tag, k), outq[k], rep(exp[k*8 +: 8]));
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] sgn_exp;
        int         quiet;
`ifdef MAXPOOL_RELU_EN
        sgn_exp = 8'h00;
`else
        sgn_exp = 8'hFE;
`endif
        vecs[0] = '{4, 4, 0, 4, {8'd15, 8'd13, 8'd7, 8'd5}};
        vecs[1] = '{5, 3, 0, 2, {16'd0, 8'd8, 8'd6}};
        vecs[2] = '{2, 2, 1, 1, {24'd0, sgn_exp}};
        vecs[3] = '{1, 4, 0, 0, 32'd0};
        vecs[4] = '{3, 1, 0, 0, 32'd0};
        vecs[5] = '{0, 5, 0, 0, 32'd0};
        vecs[6] = '{6, 2, 0, 3, {8'd0, 8'd11, 8'd9, 8'd7}};

        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        col_num = '0; row_num = '0;
        mv_seen = 0; done_cnt = 0; first_mv_cyc = 0; done_cyc = 0;
        last_hs_cyc = 0; acc11_cyc = 0; acc_cnt = 0;
        repeat (3) @(negedge clk);
        check("reset_s_ready", s_ready, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_m_data", m_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            start_map(vecs[i].cn, vecs[i].rn);
            drive(vecs[i].cn, vecs[i].rn, vecs[i].mode, vecs[i].cn * vecs[i].rn);
            wait_done();
            check_out($sformatf("vec%0d", i), vecs[i].n, vecs[i].exp);
            check($sformatf("vec%0d_done_pulses", i), done_cnt, 1);
            check($sformatf("vec%0d_idle", i), busy, 0);
            if (i == 0) begin
                check("first_m_valid_latency", first_mv_cyc, acc11_cyc + 3);
                check("done_after_last_output", done_cyc, last_hs_cyc + 2);
            end
        end

        // Output stalled: FIFO fills to 2 and input stops after exactly 11 beats.
        m_ready = 1'b0;
        start_map(4, 4);
        fork
            drive(4, 4, 0, 16);
            begin
                repeat (30) @(negedge clk);
                check("bp_beats_before_stall", acc_cnt, 11);
                check("bp_s_ready_low", s_ready, 0);
                check("bp_m_valid_high", m_valid, 1);
                check("bp_no_output", outq.size(), 0);
                m_ready = 1'b1;
            end
        join
        wait_done();
        check_out("bp", 4, {8'd15, 8'd13, 8'd7, 8'd5});
        check("bp_done_pulses", done_cnt, 1);

        // Reset during row 2 of an 8x8 map.
        start_map(8, 8);
        drive(8, 8, 0, 19);
        rst = 1'b0;
        #1;
        check("midrst_s_ready", s_ready, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_valid || busy || s_ready) quiet++;
        end
        check("midrst_no_partial_output", quiet, 0);
        start_map(2, 2);
        drive(2, 2, 0, 4);
        wait_done();
        check_out("post_rst", 1, 32'd3);
        check("post_rst_done_pulses", done_cnt, 1);

        // start while busy must be ignored.
        start_map(4, 4);
        fork
            drive(4, 4, 0, 16);
            begin
                repeat (6) @(negedge clk);
                col_num = 9'd2;
                row_num = 9'd2;
                start   = 1'b1;
                @(negedge clk);
                start   = 1'b0;
            end
        join
        wait_done();
        check_out("restart", 4, {8'd15, 8'd13, 8'd7, 8'd5});
        check("restart_done_pulses", done_cnt, 1);
        check("restart_done_timing", done_cyc, last_hs_cyc + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
